// File: rtl/tone_detector.sv
// Tone detector: measures the rise-to-rise period of an asynchronous square wave
// and declares lock after LOCK_CNT consecutive periods within TOL of 2*HALF_PERIOD.
module tone_detector #(
    parameter int IN_CLK      = 50000000,
    parameter int HALF_PERIOD = 100000,
    parameter int TOL         = 2000,
    parameter int LOCK_CNT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    output logic [26:0] period,
    output logic        period_valid,
    output logic        tone_ok,
    output logic        led
);
    localparam int CW = 27;
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int P  = 2 * HALF_PERIOD;

    localparam logic [CW-1:0] LO     = (P > TOL) ? CW'(P - TOL) : '0;
    localparam logic [CW-1:0] HI     = CW'(P + TOL);
    localparam logic [CW-1:0] TMO    = CW'(2 * P);
    localparam logic [CW-1:0] CMAX   = '1;
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);

    // IN_CLK only documents the intended clock; it does not shape any logic.
    if (IN_CLK < 1) begin : g_no_clk
    end

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [MW-1:0]   match, match_n;
    logic [CW-1:0]   period_n;
    logic            pv_n, tok_n;
    logic            s0, s1, s2, rise;
    logic            in_tol;

    // Two-flop synchronizer, one edge-history flop, and a registered rise strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            s2   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s0   <= sig_in;
            s1   <= s0;
            s2   <= s1;
            rise <= s1 & ~s2;
        end
    end

    assign in_tol = (cnt >= LO) && (cnt <= HI);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        match_n  = match;
        period_n = period;
        pv_n     = 1'b0;
        tok_n    = tone_ok;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                match_n = '0;
                tok_n   = 1'b0;
                if (rise) begin
                    state_n = MEASURE;
                    cnt_n   = CW'(1);
                end
            end
            MEASURE, LOCKED: begin
                cnt_n = (cnt == CMAX) ? cnt : cnt + CW'(1);
                if (rise) begin
                    // A rise wins over a coincident timeout.
                    cnt_n    = CW'(1);
                    period_n = cnt;
                    pv_n     = 1'b1;
                    if (in_tol) begin
                        if (state == MEASURE) begin
                            if (match + MW'(1) == LOCK_M) begin
                                state_n = LOCKED;
                                tok_n   = 1'b1;
                                match_n = LOCK_M;
                            end else begin
                                match_n = match + MW'(1);
                            end
                        end
                    end else begin
                        state_n = MEASURE;
                        match_n = '0;
                        tok_n   = 1'b0;
                    end
                end else if (cnt == TMO) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    match_n = '0;
                    tok_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                match_n = '0;
                tok_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            match        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            tone_ok      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            match        <= match_n;
            period       <= period_n;
            period_valid <= pv_n;
            tone_ok      <= tok_n;
        end
    end

    assign led = tone_ok;

endmodule
